// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
//   N_OUT         - number of output channels
//   SEL_W         - width of the destination select
//   demux_state_t - packet-lock FSM states
package stream_demux_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE,
    LOCKED
  } demux_state_t;

endpackage

// File: rtl/stream_demux_1_4_if.sv
// Bundle of the demux input stream, the four output streams and the busy flag.
//   slave  - view taken by the demux itself
//   master - view taken by the producer/consumer side (testbench)
interface stream_demux_1_4_if
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     in_last;
  logic [SEL_W-1:0]         in_sel;
  logic [N_OUT-1:0]         out_valid;
  logic [N_OUT-1:0]         out_ready;
  logic [N_OUT*WIDTH-1:0]   out_data;
  logic [N_OUT-1:0]         out_last;
  logic                     busy;

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

endinterface

// File: rtl/stream_slot.sv
// One-entry register slice for a single demux output.
//   clk, rst_n - clock and async active-low reset
//   load_i     - capture data_i/last_i this edge
//   data_i     - beat payload to capture
//   last_i     - beat last flag to capture
//   ready_i    - downstream ready
//   valid_o    - slot holds a beat
//   data_o     - held payload (kept after drain)
//   last_o     - held last flag (kept after drain)
//   free_o     - slot can accept a beat this cycle (empty or draining)
module stream_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      // A load while draining replaces the beat without a bubble.
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux_1_4.sv
// 1:4 valid/ready stream demultiplexer with per-packet destination lock.
//   clk, rst_n - clock and async active-low reset
//   bus        - input stream (in_*), four output streams (out_*), busy flag
// in_sel is honoured on the first beat of a packet and held until the last
// beat. Each output has its own one-entry slice so a stalled output never
// blocks the others.
module stream_demux_1_4
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  stream_demux_1_4_if.slave bus
);

  demux_state_t     state_q, state_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] eff_target;
  logic             in_ready;
  logic             accept;

  logic [N_OUT-1:0] slot_free;
  logic [N_OUT-1:0] slot_load;
  logic [N_OUT-1:0] slot_valid;
  logic [N_OUT-1:0] slot_last;
  logic [WIDTH-1:0] slot_data [N_OUT];

  always_comb begin
    eff_target = (state_q == LOCKED) ? target_q : bus.in_sel;
    // Ready depends only on the chosen slot, never on in_valid.
    in_ready   = slot_free[eff_target];
    accept     = bus.in_valid && in_ready;

    slot_load = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      slot_load[i] = accept && (eff_target == SEL_W'(i));
    end

    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !bus.in_last) begin
          state_d  = LOCKED;
          target_d = eff_target;
        end
      end
      LOCKED: begin
        if (accept && bus.in_last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (slot_load[g]),
      .data_i  (bus.in_data),
      .last_i  (bus.in_last),
      .ready_i (bus.out_ready[g]),
      .valid_o (slot_valid[g]),
      .data_o  (slot_data[g]),
      .last_o  (slot_last[g]),
      .free_o  (slot_free[g])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      bus.out_data[i*WIDTH +: WIDTH] = slot_data[i];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = slot_valid;
  assign bus.out_last  = slot_last;
  assign bus.busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios followed by
// random traffic, all compared against a behavioural model of four one-deep
// output buffers plus a "current packet destination" lock.
module tb_stream_demux_1_4;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  stream_demux_1_4_if #(.WIDTH(WIDTH)) bus ();

  stream_demux_1_4 #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each output holds at most one beat; a packet owns one destination.
  bit         m_valid [4];
  logic [3:0] m_data  [4];
  bit         m_last  [4];
  bit         m_locked;
  int         m_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 4'h0;
      m_last[i]  = 1'b0;
    end
    m_locked = 1'b0;
    m_dest   = 0;
  endtask

  task automatic chk_outputs(input string tag);
    logic [3:0]  ev;
    logic [15:0] ed;
    logic [3:0]  el;
    for (int i = 0; i < 4; i++) begin
      ev[i]        = m_valid[i];
      ed[i*4 +: 4] = m_data[i];
      el[i]        = m_last[i];
    end
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(ev));
    chk({tag, "_out_data"},  32'(bus.out_data),  32'(ed));
    chk({tag, "_out_last"},  32'(bus.out_last),  32'(el));
    chk({tag, "_busy"},      32'(bus.busy),      32'(m_locked));
  endtask

  task automatic drive(input bit v, input int sel, input logic [3:0] d, input bit l,
                       input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_sel    = 2'(sel);
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = rdy;
  endtask

  // Check ready for the driven inputs, clock once, update model, check outputs.
  task automatic step(input string tag);
    int         d;
    bit         exp_rdy;
    bit         acc;
    logic [3:0] rdy;
    logic [3:0] din;
    bit         lin;
    #1;
    d       = m_locked ? m_dest : int'(bus.in_sel);
    exp_rdy = !m_valid[d] || bus.out_ready[d];
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    rdy = bus.out_ready;
    din = bus.in_data;
    lin = bus.in_last;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc && d == i) begin
        m_valid[i] = 1'b1;
        m_data[i]  = din;
        m_last[i]  = lin;
      end else if (m_valid[i] && rdy[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (acc) begin
      if (!m_locked && !lin) begin
        m_locked = 1'b1;
        m_dest   = d;
      end else if (m_locked && lin) begin
        m_locked = 1'b0;
      end
    end
    chk_outputs(tag);
  endtask

  initial begin
    int sels [4];
    sels = '{2, 0, 1, 3};

    // Reset state, before any clock edge.
    rst_n = 1'b0;
    drive(1'b0, 0, 4'h0, 1'b0, 4'h0);
    model_reset();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk_outputs("rst");
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat packets to each output.
    foreach (sels[k]) begin
      drive(1'b1, sels[k], 4'hA, 1'b1, 4'hF);
      step("single");
      chk("single_onehot", 32'(bus.out_valid), 32'(4'b0001 << sels[k]));
    end
    drive(1'b0, 0, 4'h0, 1'b0, 4'hF);
    step("drain");

    // Packet lock: in_sel changes mid-packet are ignored.
    drive(1'b1, 1, 4'h1, 1'b0, 4'hF);
    step("lock1");
    drive(1'b1, 3, 4'h2, 1'b0, 4'hF);
    step("lock2");
    chk("lock2_data1", 32'(bus.out_data[7:4]), 32'h2);
    drive(1'b1, 3, 4'h3, 1'b1, 4'hF);
    step("lock3");
    chk("lock3_data1", 32'(bus.out_data[7:4]), 32'h3);
    chk("lock3_last1", 32'(bus.out_last[1]), 32'd1);

    // Backpressure on output 0, then drain and load in the same cycle.
    drive(1'b1, 0, 4'h5, 1'b1, 4'hE);
    step("bp5");
    drive(1'b1, 0, 4'h6, 1'b1, 4'hE);
    step("bp6_stall");
    chk("bp_held", 32'(bus.out_data[3:0]), 32'h5);
    step("bp6_stall2");
    drive(1'b1, 0, 4'h6, 1'b1, 4'hF);
    step("bp6_go");
    chk("bp_nobubble", 32'(bus.out_valid[0]), 32'd1);
    chk("bp_data6", 32'(bus.out_data[3:0]), 32'h6);

    // Independence: output 0 still full and stalled, output 3 takes a beat.
    drive(1'b1, 0, 4'h9, 1'b1, 4'hE);
    step("ind_fill");
    drive(1'b1, 3, 4'hC, 1'b1, 4'hE);
    step("ind");
    chk("ind_data3", 32'(bus.out_data[15:12]), 32'hC);
    drive(1'b0, 0, 4'h0, 1'b0, 4'hF);
    step("ind_drain");

    // Async reset while locked with slot 1 full.
    drive(1'b1, 1, 4'h1, 1'b0, 4'h0);
    step("ar_lock");
    drive(1'b0, 0, 4'h0, 1'b0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_outputs("ar_async");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 2, 4'h7, 1'b1, 4'hF);
    step("ar_after");
    chk("ar_after_valid", 32'(bus.out_valid), 32'h4);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 4'($urandom),
            ($urandom_range(0, 2) == 0), 4'($urandom));
      step("rnd");
    end

    drive(1'b0, 0, 4'h0, 1'b0, 4'hF);
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
- Routes one valid/ready input stream to one of four output streams. It is the distribution-side counterpart of the 4:1 data mux.
- The destination is selected per packet: `in_sel` is sampled on the first beat and held until the last beat.
- Each output has its own one-entry register slice, so a stalled output does not block traffic to the other outputs.
- Sits between a single producer and four consumer channels in the datapath.

Parameters:
- WIDTH, 4, data width per beat.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  WIDTH  input beat payload.
- in_last  input  1  last beat of packet.
- in_sel  input  2  destination index; honoured only on the first beat of a packet.
- out_valid  output  4  per-output valid; bit i belongs to output i.
- out_ready  input  4  per-output ready.
- out_data  output  4*WIDTH  output i payload at [i*WIDTH +: WIDTH].
- out_last  output  4  per-output last flag.
- busy  output  1  high while a multi-beat packet is in progress (state LOCKED).

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, state=IDLE, target=0, busy=0. Takes effect immediately, without waiting for a clock edge.
- Reset mid-packet: all buffered beats are discarded. After release the block is in IDLE and the next beat's in_sel is honoured.
- State machine:
  - IDLE: effective target = in_sel.
    - On an accepted beat with in_last=0: store target = in_sel and go to LOCKED.
    - On an accepted beat with in_last=1: stay in IDLE.
  - LOCKED: effective target = stored target; in_sel is ignored.
    - On an accepted beat with in_last=1: go to IDLE.
    - Otherwise: stay in LOCKED.
- Slot i is free when !out_valid[i] || out_ready[i]. A full slot that is draining in the same cycle counts as free.
- in_ready = free(effective target). It is combinational from state, in_sel and out_valid/out_ready, and must not depend on in_valid.
- On an accepted beat:
  - The target slot loads in_data and in_last, and its out_valid is set on the next edge.
  - Latency is 1 cycle from input accept to out_valid.
  - Throughput is 1 beat per cycle per slot when the output is always ready.
- Slot i with out_valid[i] && out_ready[i] and no new load: out_valid[i] clears on the next edge. Data and last keep their old values.
- Non-target slots hold or drain independently of input activity.
- in_valid=0: no state change and no slot load.
- Simultaneous drain and load on the same slot: the new beat is loaded, out_valid stays 1, and no bubble is inserted.
- in_sel takes values 0..3 only, so there is no out-of-range case.

Decomposition:
- Package stream_demux_pkg holds:
  - N_OUT = 4 and SEL_W = 2.
  - typedef enum logic {IDLE, LOCKED} demux_state_t.
- Sub-module stream_slot (one-entry register slice; ports: clk, rst_n, load, data/last in, valid/data/last out, ready, free) is instantiated 4 times with a generate loop.
- The top level contains only the FSM, target register and in_ready/load decode.

Test Plan:
- Reset: hold rst_n=0 with in_sel=0 -> out_valid=4'b0000, busy=0, in_ready=1.
- Single-beat packet: in_sel=2, in_data=4'hA, in_last=1, out_ready=4'hF -> next cycle out_valid=4'b0100, out_data[11:8]=4'hA, out_last[2]=1, busy=0 throughout. Repeat for outputs 0, 1 and 3.
- Packet lock: 3 beats with data 1, 2, 3; in_sel=1 on beat 1, in_sel=3 on beats 2–3 -> all three beats appear on output 1 in order with out_last[1] only on data 3. busy=1 after beats 1 and 2, busy=0 after beat 3.
- Backpressure and throughput: out_ready[0]=0; send beats 5 then 6 to output 0 -> beat 5 is held and in_ready=0 while beat 6 is pending. Raise out_ready[0] -> beat 5 drains and beat 6 loads in the same cycle, and out_valid[0] stays 1.
- Independence: output 0 full and stalled; send a single-beat packet with 4'hC to in_sel=3 -> accepted immediately, and out_valid[3]=1 with data 4'hC next cycle while output 0 is unchanged.
- Async reset mid-packet: assert rst_n=0 between clock edges while in LOCKED with slot 1 full -> out_valid=0 and busy=0 before the next edge. After release, a beat with in_sel=2 is routed to output 2.
